// File: rtl/regbank_wr_arbiter.sv
// regbank_wr_arbiter
// ------------------
// Round-robin arbiter sharing the single write port of the register bank
// among NREQ requesters (ALU writeback, load unit, debug port, ...).
// A winner owns the port until it drops its request, flags its last beat,
// or has written MAX_BURST beats. Exactly one arbitration (IDLE) cycle
// separates consecutive owners.
//
// Optional feature (macro REGARB_PRIO0_EN): requester 0 wins every
// arbitration it takes part in, and its release does not advance the
// round-robin pointer. Ownership is never preempted mid-burst.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   req       in   [NREQ]        per-requester request / beat valid
//   req_last  in   [NREQ]        per-requester last-beat flag
//   req_addr  in   [NREQ*ADDR_W] packed addresses, slice i at [i*ADDR_W +: ADDR_W]
//   req_data  in   [NREQ*WIDTH]  packed data, slice i at [i*WIDTH +: WIDTH]
//   gnt       out  [NREQ]        registered one-hot grant
//   wr_en     out                registered bank write strobe
//   wr_addr   out  [ADDR_W]      registered bank write address
//   wr_data   out  [WIDTH]       registered bank write data
//   busy      out                registered, high while a requester owns the port

module regbank_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 9,
  parameter int ADDR_W    = 3,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          gnt,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [WIDTH-1:0]         wr_data,
  output logic                     busy
);

  localparam int          IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0]  LAST_BEAT = 4'(MAX_BURST - 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t              state_r;
  logic [IDX_W-1:0]    ptr_r;
  logic [IDX_W-1:0]    owner_r;
  logic [3:0]          beat_cnt_r;
  logic [NREQ-1:0]     gnt_r;
  logic                wr_en_r;
  logic [ADDR_W-1:0]   wr_addr_r;
  logic [WIDTH-1:0]    wr_data_r;
  logic                busy_r;

  logic                found_s;
  logic [IDX_W-1:0]    win_s;
  logic                beat_s;
  logic                last_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [WIDTH-1:0]    sel_data_s;
  logic                release_s;
  logic [IDX_W-1:0]    rel_ptr_s;

  // Successor index, wrapping modulo NREQ (NREQ need not be a power of two).
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(NREQ - 1)) begin
      return {IDX_W{1'b0}};
    end else begin
      return i + IDX_W'(1);
    end
  endfunction

  // One-hot decode of a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NREQ-1:0] v;
    v = {NREQ{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      if (i == IDX_W'(k)) begin
        v[k] = 1'b1;
      end else begin
        v[k] = 1'b0;
      end
    end
    return v;
  endfunction

  // Winner search: first pass covers indices at or above ptr, second pass
  // the wrapped-around indices below ptr, giving a modulo-NREQ scan.
  always_comb begin
    found_s = 1'b0;
    win_s   = ptr_r;
    for (int i = 0; i < NREQ; i++) begin
      if (!found_s && req[i] && (IDX_W'(i) >= ptr_r)) begin
        found_s = 1'b1;
        win_s   = IDX_W'(i);
      end else begin
        found_s = found_s;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found_s && req[i] && (IDX_W'(i) < ptr_r)) begin
        found_s = 1'b1;
        win_s   = IDX_W'(i);
      end else begin
        found_s = found_s;
      end
    end
`ifdef REGARB_PRIO0_EN
    if (req[0]) begin
      found_s = 1'b1;
      win_s   = {IDX_W{1'b0}};
    end else begin
      found_s = found_s;
    end
`endif
  end

  // Select the current owner's request, last flag, address and data.
  always_comb begin
    beat_s     = 1'b0;
    last_s     = 1'b0;
    sel_addr_s = {ADDR_W{1'b0}};
    sel_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (owner_r == IDX_W'(i)) begin
        beat_s     = req[i];
        last_s     = req_last[i];
        sel_addr_s = req_addr[i*ADDR_W +: ADDR_W];
        sel_data_s = req_data[i*WIDTH +: WIDTH];
      end else begin
        beat_s = beat_s;
      end
    end
  end

  // Release conditions while owning; the forced-release beat is still written.
  always_comb begin
    release_s = !beat_s || last_s || (beat_cnt_r == LAST_BEAT);
`ifdef REGARB_PRIO0_EN
    if (owner_r == {IDX_W{1'b0}}) begin
      rel_ptr_s = ptr_r;
    end else begin
      rel_ptr_s = next_idx(owner_r);
    end
`else
    rel_ptr_s = next_idx(owner_r);
`endif
  end

  // Arbitration FSM with registered grant and write-port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      ptr_r      <= {IDX_W{1'b0}};
      owner_r    <= {IDX_W{1'b0}};
      beat_cnt_r <= 4'd0;
      gnt_r      <= {NREQ{1'b0}};
      wr_en_r    <= 1'b0;
      wr_addr_r  <= {ADDR_W{1'b0}};
      wr_data_r  <= {WIDTH{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          wr_en_r <= 1'b0;
          if (found_s) begin
            state_r    <= OWN;
            owner_r    <= win_s;
            beat_cnt_r <= 4'd0;
            gnt_r      <= onehot(win_s);
            busy_r     <= 1'b1;
          end else begin
            gnt_r  <= {NREQ{1'b0}};
            busy_r <= 1'b0;
          end
        end
        OWN: begin
          if (beat_s) begin
            wr_en_r    <= 1'b1;
            wr_addr_r  <= sel_addr_s;
            wr_data_r  <= sel_data_s;
            beat_cnt_r <= beat_cnt_r + 4'd1;
          end else begin
            // address and data hold; only the strobe drops
            wr_en_r <= 1'b0;
          end
          if (release_s) begin
            state_r <= IDLE;
            gnt_r   <= {NREQ{1'b0}};
            busy_r  <= 1'b0;
            ptr_r   <= rel_ptr_s;
          end else begin
            state_r <= OWN;
          end
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= {NREQ{1'b0}};
          wr_en_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = gnt_r;
  assign wr_en   = wr_en_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Self-checking bench for regbank_wr_arbiter: directed scenarios with
// literal expectations plus randomized traffic, all compared every cycle
// against a cycle-level behavioural model of the arbitration rules.

module tb_regbank_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int WIDTH     = 9;
  localparam int ADDR_W    = 3;
  localparam int MAX_BURST = 4;

  logic                   clk;
  logic                   reset;
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_last;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*WIDTH-1:0]  req_data;
  logic [NREQ-1:0]        gnt;
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic                   busy;

  int checks;
  int errors;
  int wcnt;

  regbank_wr_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_last(req_last),
    .req_addr(req_addr), .req_data(req_data), .gnt(gnt), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit                m_own;
  int                m_ptr;
  int                m_owner;
  int                m_cnt;
  logic [NREQ-1:0]   e_gnt;
  logic              e_wr_en;
  logic [ADDR_W-1:0] e_addr;
  logic [WIDTH-1:0]  e_data;
  logic              e_busy;

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    int w;
    w = -1;
`ifdef REGARB_PRIO0_EN
    if (r[0]) w = 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (p + k) % NREQ;
      if (w < 0 && r[c[1:0]]) w = c;
    end
    return w;
  endfunction

  function automatic int next_ptr(input int owner, input int p);
`ifdef REGARB_PRIO0_EN
    if (owner == 0) return p;
`endif
    return (owner + 1) % NREQ;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_own <= 1'b0; m_ptr <= 0; m_owner <= 0; m_cnt <= 0;
      e_gnt <= '0; e_wr_en <= 1'b0; e_addr <= '0; e_data <= '0; e_busy <= 1'b0;
    end else if (!m_own) begin
      e_wr_en <= 1'b0;
      if (pick(req, m_ptr) >= 0) begin
        m_own   <= 1'b1;
        m_owner <= pick(req, m_ptr);
        m_cnt   <= 0;
        e_gnt   <= NREQ'(1 << pick(req, m_ptr));
        e_busy  <= 1'b1;
      end else begin
        e_gnt  <= '0;
        e_busy <= 1'b0;
      end
    end else begin
      if (req[m_owner[1:0]]) begin
        e_wr_en <= 1'b1;
        e_addr  <= ADDR_W'(req_addr >> (m_owner * ADDR_W));
        e_data  <= WIDTH'(req_data >> (m_owner * WIDTH));
        m_cnt   <= m_cnt + 1;
      end else begin
        e_wr_en <= 1'b0;
      end
      if (!req[m_owner[1:0]] || req_last[m_owner[1:0]] || (m_cnt + 1 == MAX_BURST)) begin
        m_own  <= 1'b0;
        e_gnt  <= '0;
        e_busy <= 1'b0;
        m_ptr  <= next_ptr(m_owner, m_ptr);
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("wr_en", 32'(wr_en), 32'(e_wr_en));
      chk("wr_addr", 32'(wr_addr), 32'(e_addr));
      chk("wr_data", 32'(wr_data), 32'(e_data));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("busy_eq_gnt", 32'(busy), 32'(|gnt));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic setr(input int i, input bit r, input bit l,
                      input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    req      = (req & ~(NREQ'(1) << i)) | (NREQ'(r) << i);
    req_last = (req_last & ~(NREQ'(1) << i)) | (NREQ'(l) << i);
    req_addr = (req_addr & ~((NREQ*ADDR_W)'(3'h7) << (i*ADDR_W))) |
               ((NREQ*ADDR_W)'(a) << (i*ADDR_W));
    req_data = (req_data & ~((NREQ*WIDTH)'(9'h1FF) << (i*WIDTH))) |
               ((NREQ*WIDTH)'(d) << (i*WIDTH));
  endtask

  task automatic clear_all();
    req = '0; req_last = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; wcnt = 0;
    reset = 1'b1;
    req = '0; req_last = '0; req_addr = '0; req_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_wr_data", 32'(wr_data), 32'd0);

    // Single requester, two beats, last on the second
    setr(1, 1'b1, 1'b0, 3'd3, 9'h1A5);
    @(negedge clk);
    chk("single_gnt", 32'(gnt), 32'h2);
    @(negedge clk);
    chk("single_w1_en", 32'(wr_en), 32'd1);
    chk("single_w1_addr", 32'(wr_addr), 32'd3);
    chk("single_w1_data", 32'(wr_data), 32'h1A5);
    setr(1, 1'b1, 1'b1, 3'd4, 9'h0F0);
    @(negedge clk);
    chk("single_w2_en", 32'(wr_en), 32'd1);
    chk("single_w2_addr", 32'(wr_addr), 32'd4);
    chk("single_w2_data", 32'(wr_data), 32'h0F0);
    chk("single_rel_gnt", 32'(gnt), 32'd0);
    chk("single_model_ptr", 32'(m_ptr), 32'd2);
    setr(1, 1'b0, 1'b0, 3'd0, 9'h000);
    @(negedge clk);
    chk("single_after_en", 32'(wr_en), 32'd0);

    // Contention from reset: 0 then 2, then wrap back to 0
    do_reset();
    setr(0, 1'b1, 1'b1, 3'd1, 9'h011);
    setr(2, 1'b1, 1'b1, 3'd5, 9'h022);
    @(negedge clk);
    chk("cont_gnt0", 32'(gnt), 32'h1);
    @(negedge clk);
    chk("cont_w0_addr", 32'(wr_addr), 32'd1);
    chk("cont_idle_gnt", 32'(gnt), 32'd0);
    setr(0, 1'b0, 1'b0, 3'd0, 9'h000);
    @(negedge clk);
    chk("cont_gnt2", 32'(gnt), 32'h4);
    @(negedge clk);
    chk("cont_w2_data", 32'(wr_data), 32'h022);
    chk("cont_model_ptr", 32'(m_ptr), 32'd3);
    setr(0, 1'b1, 1'b1, 3'd2, 9'h033);
    setr(2, 1'b1, 1'b1, 3'd6, 9'h044);
    @(negedge clk);
    chk("cont_wrap_gnt0", 32'(gnt), 32'h1);
    @(negedge clk);
    chk("cont_wrap_w_addr", 32'(wr_addr), 32'd2);
    clear_all();
    repeat (3) @(negedge clk);

    // Forced release after MAX_BURST beats, then re-grant
    setr(3, 1'b1, 1'b0, 3'd7, 9'h1FF);
    wcnt = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      wcnt += int'(wr_en);
    end
    chk("forced_writes", 32'(wcnt), 32'd4);
    chk("forced_gnt_drop", 32'(gnt), 32'd0);
    @(negedge clk);
    chk("forced_regrant", 32'(gnt), 32'h8);
    repeat (4) @(negedge clk);
    clear_all();
    repeat (3) @(negedge clk);

    // Drop mid-burst after two beats
    setr(1, 1'b1, 1'b0, 3'd2, 9'h0AA);
    wcnt = 0;
    @(negedge clk);
    chk("drop_gnt", 32'(gnt), 32'h2);
    @(negedge clk); wcnt += int'(wr_en);
    @(negedge clk); wcnt += int'(wr_en);
    setr(1, 1'b0, 1'b0, 3'd2, 9'h0AA);
    @(negedge clk); wcnt += int'(wr_en);
    chk("drop_writes", 32'(wcnt), 32'd2);
    chk("drop_gnt_zero", 32'(gnt), 32'd0);
    chk("drop_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);

    // Reset between edges during a beat of requester 2
    setr(2, 1'b1, 1'b0, 3'd5, 9'h155);
    @(negedge clk);
    chk("rst_mid_gnt", 32'(gnt), 32'h4);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_gnt0", 32'(gnt), 32'd0);
    chk("rst_mid_wr_en0", 32'(wr_en), 32'd0);
    chk("rst_mid_busy0", 32'(busy), 32'd0);
    setr(0, 1'b1, 1'b1, 3'd1, 9'h012);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_after_gnt0", 32'(gnt), 32'h1);
    clear_all();
    repeat (3) @(negedge clk);

    // Requester 0 and 3 wait while 2 owns; 2 releases
    setr(2, 1'b1, 1'b0, 3'd3, 9'h101);
    @(negedge clk);
    chk("prio_gnt2", 32'(gnt), 32'h4);
    setr(2, 1'b1, 1'b1, 3'd3, 9'h101);
    setr(0, 1'b1, 1'b1, 3'd0, 9'h055);
    setr(3, 1'b1, 1'b1, 3'd7, 9'h0CC);
    @(negedge clk);
    setr(2, 1'b0, 1'b0, 3'd0, 9'h000);
    @(negedge clk);
`ifdef REGARB_PRIO0_EN
    chk("prio_next_gnt", 32'(gnt), 32'h1);
`else
    chk("prio_next_gnt", 32'(gnt), 32'h8);
`endif
    clear_all();
    repeat (4) @(negedge clk);

    // Randomized traffic with occasional asynchronous resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
      end
      req_last = NREQ'($urandom) & NREQ'($urandom);
      req_addr = (NREQ*ADDR_W)'($urandom);
      req_data = (NREQ*WIDTH)'({$urandom, $urandom});
      if (cyc == 1000 || cyc == 2200) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    clear_all();
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regbank_wr_arbiter.md
Name: regbank_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the register bank (a bank of reset-able WIDTH-bit registers) among NREQ requesters.
- Grants one requester at a time, with burst locking and a forced release after MAX_BURST beats.
- Drives registered write enable, address and data into the bank.
- Sits between the datapath units (ALU writeback, load unit, debug port) and the register bank.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 9, data width of each bank register.
- ADDR_W, 3, bank address width.
- MAX_BURST, 4, maximum beats per grant before forced release (1..15).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- req  input  NREQ  per-requester request/valid; bit i belongs to requester i.
- req_last  input  NREQ  per-requester last-beat flag; sampled only on a beat.
- req_addr  input  NREQ*ADDR_W  packed addresses; slice i is [i*ADDR_W +: ADDR_W].
- req_data  input  NREQ*WIDTH  packed write data; slice i is [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant, registered.
- wr_en  output  1  bank write strobe, registered.
- wr_addr  output  ADDR_W  bank write address, registered.
- wr_data  output  WIDTH  bank write data, registered.
- busy  output  1  high while a requester owns the port.

Behaviour:
- Clock and reset: clk, rising edge; reset is asynchronous, active-high.
- Reset values: state=IDLE, ptr=0, owner=0, beat_cnt=0, gnt=0, wr_en=0, wr_addr=0, wr_data=0, busy=0. All are cleared immediately on reset assertion.
- Reset mid-burst: the in-flight beat is dropped and no write is issued. The first grant after reset release goes to the lowest-indexed active requester.
- FSM has two states, IDLE and OWN.
- IDLE (arbitration cycle):
  - If any req bit is set, choose the first set bit scanning from ptr upward, wrapping modulo NREQ.
  - Next edge: owner=winner, gnt=one-hot(winner), beat_cnt=0, state=OWN.
  - If no req bit is set, stay in IDLE with gnt=0.
- OWN:
  - A beat is any cycle with req[owner]=1.
  - On a beat: at the next edge wr_en=1, wr_addr=req_addr slice[owner], wr_data=req_data slice[owner], and beat_cnt increments.
  - Latency is exactly 1 cycle from beat to write strobe.
  - On a non-beat cycle: wr_en=0 at the next edge; wr_addr and wr_data hold their previous values.
- Release from OWN happens at the edge following any of:
  - req[owner]=0 (drop; no write that cycle);
  - a beat with req_last[owner]=1;
  - a beat with beat_cnt==MAX_BURST-1 (forced release; that beat is still written).
- On release: gnt=0, state=IDLE, ptr=(owner+1) mod NREQ.
  - Exactly one arbitration cycle separates consecutive owners, so gnt is never asserted for two different requesters in adjacent cycles.
- Requests from non-owners during OWN are ignored and must be held by the requester. req_last is ignored when req is low.
- Simultaneous events:
  - Release and a new request in the same cycle: the request is serviced in the following IDLE cycle.
  - A requester that is released but keeps req high re-competes in IDLE with the lowest priority, because ptr has advanced past it.
- busy equals (state==OWN). It is registered and aligned with gnt.
- Invariants:
  - gnt is zero or one-hot.
  - wr_en is high only in the cycle after a beat by the current or just-released owner.

Optional Feature:
- Macro: REGARB_PRIO0_EN.
- Defined: requester 0 has fixed top priority. In IDLE, req[0]=1 wins regardless of ptr, and ptr is not advanced when requester 0 releases. MAX_BURST still applies to requester 0. Other requesters are not preempted mid-burst.
- Undefined: pure round-robin as described above.

Test Plan:
- Single requester: req[1] with addr 3, data 0x1A5 then addr 4, data 0x0F0, last on beat 2.
  - Required: gnt=0010 one cycle after req.
  - Required: wr_en pulses on 2 consecutive cycles with exactly those values.
  - Required: gnt=0 after, then ptr=2.
- Contention: req[0] and req[2] raised together from reset, each sending 1 beat with last.
  - Required grant order: requester 0, an IDLE cycle, then requester 2. Writes appear in that order.
  - Then req[0] and req[2] again: requester 2 is not granted first; with ptr=3 the scan wraps and requester 0 wins.
- Forced release: req[3] held high with req_last=0 for 10 cycles, MAX_BURST=4.
  - Required: exactly 4 writes, then gnt drops.
  - Required: after one IDLE cycle requester 3 is re-granted if alone.
- Drop mid-burst: requester 1 makes 2 beats, then deasserts req.
  - Required: 2 writes, no third write, gnt=0 on the next edge, busy=0.
- Reset mid-burst: assert reset asynchronously between edges during a beat of requester 2.
  - Required: gnt, wr_en and busy go to 0 immediately, with no write issued for that beat.
  - Required: after release with req[0] and req[2] set, requester 0 is granted first.
- With REGARB_PRIO0_EN: requester 2 owns the port; req[0] and req[3] rise; requester 2 releases.
  - Required: requester 0 is granted in the next IDLE cycle, ahead of requester 3.
